// File: rtl/prog_loader_pkg.sv
// Shared types and width helpers for the CLB row configuration loader.
package prog_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitWord,
    StShift,
    StDone
  } prog_state_t;

  localparam int unsigned DefaultWordW = 32;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefaultIdxW = cnt_w(DefaultWordW);

endpackage

// File: rtl/prog_loader_if.sv
// Host-to-loader configuration word stream (valid/ready).
interface prog_loader_if
  import prog_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW
) ();

  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/prog_readback_capture.sv
// Collects bits leaving the chain tail into host-width readback words; built only when
// PROG_READBACK_EN is defined.
module prog_readback_capture
  import prog_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_shift_en,
  input  logic              i_bit,
  input  logic              i_flush,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_rb_data,
  output logic              o_rb_valid
);

  localparam int unsigned IdxW = cnt_w(WORD_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_W - 1);

  logic [WORD_W-1:0] r_shreg;
  logic [IdxW-1:0]   r_cnt;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [IdxW:0]     w_pad;

  assign w_shreg_nxt = {r_shreg[WORD_W-2:0], i_bit};
  // Left-align a partial word: the captured bits sit in the low r_cnt positions.
  assign w_pad       = (IdxW + 1)'(WORD_W) - {1'b0, r_cnt};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (i_clear) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if (i_shift_en) begin
        r_shreg <= w_shreg_nxt;
        if (r_cnt == LastIdx) begin
          r_cnt      <= '0;
          r_rb_data  <= w_shreg_nxt;
          r_rb_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (i_flush && (r_cnt != '0)) begin
        r_rb_data  <= r_shreg << w_pad;
        r_rb_valid <= 1'b1;
        r_cnt      <= '0;
        r_shreg    <= '0;
      end
    end
  end

  assign o_rb_data  = r_rb_data;
  assign o_rb_valid = r_rb_valid;

endmodule

// File: rtl/prog_loader.sv
// Serializes host configuration words MSB-first onto a CLB row scan chain.
// Optional readback capture of the chain tail is enabled by defining PROG_READBACK_EN.
module prog_loader
  import prog_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 512,
  parameter int unsigned WORD_W    = DefaultWordW
) (
  input  logic              i_prog_clk,
  input  logic              i_prog_rst_n,
  input  logic              i_cfg_start,
  input  logic              i_cfg_abort,
  prog_loader_if.slave      io_wr,
  output logic              o_chain_prog_in,
  output logic              o_chain_prog_en,
  input  logic              i_chain_prog_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [WORD_W-1:0] o_rb_data,
  output logic              o_rb_valid
);

  localparam int unsigned CntW = cnt_w(CHAIN_LEN + 1);
  localparam int unsigned IdxW = cnt_w(WORD_W);
  localparam logic [CntW-1:0] LastBit = CntW'(CHAIN_LEN - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_W - 1);

  prog_state_t       r_state;
  logic [WORD_W-1:0] r_sreg;
  logic [CntW-1:0]   r_cnt;
  logic [IdxW-1:0]   r_idx;
  logic              r_wr_ready;
  logic              r_prog_in;
  logic              r_prog_en;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_hs;
  logic [CntW-1:0]   w_cnt_nxt;
  logic [IdxW-1:0]   w_idx_nxt;

  assign w_hs      = io_wr.wr_valid & r_wr_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge i_prog_clk or negedge i_prog_rst_n) begin
    if (!i_prog_rst_n) begin
      r_state    <= StIdle;
      r_sreg     <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wr_ready <= 1'b0;
      r_prog_in  <= 1'b0;
      r_prog_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_cfg_abort) begin
        // Abort outranks everything; in IDLE it only suppresses a coincident start.
        if (r_state != StIdle) begin
          r_state    <= StIdle;
          r_prog_en  <= 1'b0;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_aborted  <= 1'b1;
        end
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_cfg_start) begin
              r_cnt      <= '0;
              r_aborted  <= 1'b0;
              r_state    <= StWaitWord;
              r_busy     <= 1'b1;
              r_wr_ready <= 1'b1;
            end
          end
          StWaitWord: begin
            if (w_hs) begin
              r_sreg     <= io_wr.wr_data;
              r_prog_in  <= io_wr.wr_data[WORD_W-1];
              r_idx      <= '0;
              r_state    <= StShift;
              r_prog_en  <= 1'b1;
              r_wr_ready <= 1'b0;
            end
          end
          StShift: begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == LastBit) begin
              r_state    <= StDone;
              r_prog_en  <= 1'b0;
              r_wr_ready <= 1'b0;
              r_done     <= 1'b1;
            end else if (r_idx == LastIdx) begin
              if (w_hs) begin
                r_sreg     <= io_wr.wr_data;
                r_prog_in  <= io_wr.wr_data[WORD_W-1];
                r_idx      <= '0;
                r_wr_ready <= 1'b0;
              end else begin
                r_state    <= StWaitWord;
                r_prog_en  <= 1'b0;
                r_wr_ready <= 1'b1;
              end
            end else begin
              r_sreg     <= r_sreg << 1;
              r_prog_in  <= r_sreg[WORD_W-2];
              r_idx      <= w_idx_nxt;
              // Open the window one cycle early so the next word lands with no bubble.
              r_wr_ready <= (w_idx_nxt == LastIdx) && (w_cnt_nxt != LastBit);
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_wr.wr_ready  = r_wr_ready;
  assign o_chain_prog_in = r_prog_in;
  assign o_chain_prog_en = r_prog_en;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_aborted       = r_aborted;

`ifdef PROG_READBACK_EN
  logic w_rb_clear;
  assign w_rb_clear = i_cfg_abort | (r_state == StIdle);

  prog_readback_capture #(
    .WORD_W (WORD_W)
  ) u_readback (
    .i_clk      (i_prog_clk),
    .i_rst_n    (i_prog_rst_n),
    .i_shift_en (r_prog_en),
    .i_bit      (i_chain_prog_out),
    .i_flush    (r_done),
    .i_clear    (w_rb_clear),
    .o_rb_data  (o_rb_data),
    .o_rb_valid (o_rb_valid)
  );
`else
  logic w_unused_tail;
  assign w_unused_tail = i_chain_prog_out;
  assign o_rb_data     = '0;
  assign o_rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized bench for prog_loader (CHAIN_LEN=40, WORD_W=32).
module tb_prog_loader;

  localparam int unsigned ChainLen = 40;
  localparam int unsigned WordW    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic             cfg_abort = 1'b0;
  logic             prog_in, prog_en, prog_out, busy, done, aborted, rb_valid;
  logic [WordW-1:0] rb_data;

  prog_loader_if #(.WORD_W(WordW)) bus ();

  prog_loader #(
    .CHAIN_LEN (ChainLen),
    .WORD_W    (WordW)
  ) dut (
    .i_prog_clk       (clk),
    .i_prog_rst_n     (rst_n),
    .i_cfg_start      (cfg_start),
    .i_cfg_abort      (cfg_abort),
    .io_wr            (bus),
    .o_chain_prog_in  (prog_in),
    .o_chain_prog_en  (prog_en),
    .i_chain_prog_out (prog_out),
    .o_busy           (busy),
    .o_done           (done),
    .o_aborted        (aborted),
    .o_rb_data        (rb_data),
    .o_rb_valid       (rb_valid)
  );

  always #5 clk = ~clk;

  // Behavioural scan chain: head takes prog_in, tail drives prog_out.
  logic [ChainLen-1:0] chain = '0;
  logic [ChainLen-1:0] chain_preset = '0;
  logic                chain_load = 1'b0;
  always @(posedge clk) begin
    if (chain_load) chain <= chain_preset;
    else if (prog_en) chain <= {chain[ChainLen-2:0], prog_in};
  end
  assign prog_out = chain[ChainLen-1];

  int vectors = 0;
  int miscompares = 0;

  // Observation of what the chain actually receives.
  bit          bitq[$];
  logic [31:0] rbq[$];
  int          cyc = 0, bubbles = 0, done_cnt = 0, last_en_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (prog_en) begin
      bitq.push_back(prog_in);
      last_en_cyc = cyc;
    end else if (busy && !done && bitq.size() > 0) begin
      bubbles++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rb_valid) rbq.push_back(rb_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bitq.delete();
    rbq.delete();
    bubbles = 0;
    done_cnt = 0;
    done_cyc = 0;
    last_en_cyc = 0;
  endtask

  function automatic logic [63:0] obs_seq();
    logic [63:0] v = '0;
    foreach (bitq[i]) v = {v[62:0], 1'(bitq[i])};
    return v;
  endfunction

  // Reference: the chain receives the word stream MSB-first, truncated to ChainLen bits.
  function automatic logic [63:0] ref_seq(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] cat;
    cat = {w0, w1};
    return 64'(cat >> (64 - ChainLen));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", bus.wr_ready, 1);
  endtask

  task automatic push(input logic [31:0] w);
    bus.wr_data  = w;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.wr_ready) break;
      @(negedge clk);
    end
    check("push_ready", bus.wr_ready, 1);
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      step();
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_shifts(input int n);
    for (int i = 0; i < 300; i++) begin
      if (bitq.size() >= n) break;
      step();
    end
    check("shift_progress", 64'(bitq.size() >= n), 1);
  endtask

  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int stall);
    chain_preset = 40'({$urandom(), $urandom()});
    chain_load = 1'b1;
    step();
    chain_load = 1'b0;
    clear_mon();
    start_pulse();
    push(w0);
    if (stall > 0) begin
      bus.wr_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (bus.wr_ready) break;
        step();
      end
      repeat (stall) step();
    end
    push(w1);
    bus.wr_valid = 1'b0;
    wait_idle();
    repeat (2) step();
    check("bit_count", bitq.size(), ChainLen);
    check("bit_seq", obs_seq(), ref_seq(w0, w1));
    check("bubbles", bubbles, stall);
    check("done_count", done_cnt, 1);
    check("done_timing", done_cyc, last_en_cyc + 1);
    check("aborted_clear", aborted, 0);
`ifdef PROG_READBACK_EN
    check("rb_count", rbq.size(), 2);
    if (rbq.size() == 2) begin
      check("rb_word0", rbq[0], chain_preset[39:8]);
      check("rb_word1", rbq[1], {chain_preset[7:0], 24'h0});
    end
`else
    check("rb_count", rbq.size(), 0);
`endif
  endtask

  initial begin
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    #12;
    check("reset_outs", {prog_in, prog_en, busy, done, aborted, bus.wr_ready, rb_valid}, 0);
    check("reset_rb_data", rb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back and host-stall loads with the reference words.
    run_load(32'h8000_0001, 32'hA5FF_FFFF, 0);
    check("b2b_seq_const", obs_seq(), 64'h80_0000_01A5);
    run_load(32'h8000_0001, 32'hA5FF_FFFF, 5);

    // Abort mid-shift.
    clear_mon();
    start_pulse();
    push($urandom());
    bus.wr_valid = 1'b0;
    wait_shifts(10);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("abort_en", prog_en, 0);
    check("abort_flag", aborted, 1);
    check("abort_busy", busy, 0);
    repeat (50) step();
    check("abort_no_done", done_cnt, 0);
    check("abort_bits", bitq.size(), 11);

    // Start together with abort in IDLE: abort wins.
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    check("start_abort_idle", busy, 0);
    start_pulse();
    check("start_clears_abort", aborted, 0);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("abort_wait_word", {busy, aborted}, 2'b01);

    // Reset asserted mid-shift.
    clear_mon();
    start_pulse();
    push($urandom());
    bus.wr_valid = 1'b0;
    wait_shifts(20);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", {prog_in, prog_en, busy, done, aborted, bus.wr_ready, rb_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("rst_no_done", done_cnt, 0);
    run_load($urandom(), $urandom(), 0);

    // Start pulse while shifting has no effect.
    clear_mon();
    start_pulse();
    push(32'hDEAD_BEEF);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    push(32'h1234_5678);
    bus.wr_valid = 1'b0;
    wait_idle();
    repeat (2) step();
    check("busy_start_bits", bitq.size(), ChainLen);
    check("busy_start_seq", obs_seq(), ref_seq(32'hDEAD_BEEF, 32'h1234_5678));
    check("busy_start_done", done_cnt, 1);

    // Randomized words and stall lengths.
    for (int i = 0; i < 6; i++) run_load($urandom(), $urandom(), int'($urandom_range(0, 4)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
